mem_req_scheduler: RTL and testbench

Fixed-priority memory request scheduler with starvation protection and in-order response routing. It sits between the CPU's memory requesters (instruction fetch, data access) and the single external `mem_req`/`mem_resp` channel pair. It grants one request per accepted transfer, records the issuing master in a route FIFO, and steers each returning response back to that master in issue order. The data port (`PRIO_IDX`) is the privileged requester.

---
 rtl/mem_req_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_mem_req_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_scheduler.sv
`default_nettype none
// ============================================================================
// mem_req_scheduler : fixed-priority memory request scheduler with starvation
//                     protection and in-order response routing
// Revision          : 1.0
// ============================================================================
module mem_req_scheduler #(
    parameter int CNT          = 2,
    parameter int QUEUE_DEPTH  = 2,
    parameter int PRIO_IDX     = 1,
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CNT-1:0]               master_req_valid,
    output logic [CNT-1:0]               master_req_ready,
    input  logic [CNT-1:0][ADDR_W-1:0]   master_req_data,
    output logic [CNT-1:0]               master_resp_valid,
    input  logic [CNT-1:0]               master_resp_ready,
    output logic [CNT-1:0][DATA_W-1:0]   master_resp_data,
    output logic                         slave_req_valid,
    input  logic                         slave_req_ready,
    output logic [ADDR_W-1:0]            slave_req_data,
    input  logic                         slave_resp_valid,
    output logic                         slave_resp_ready,
    input  logic [DATA_W-1:0]            slave_resp_data
);

    localparam int IDX_W = (CNT > 1) ? $clog2(CNT) : 1;
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [IDX_W-1:0] PRIO     = IDX_W'(PRIO_IDX);
    localparam logic [IDX_W-1:0] RR_INIT  = (PRIO_IDX == 0) ? IDX_W'(1) : IDX_W'(0);
    localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QUEUE_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);

    logic [IDX_W-1:0] fifo_q [QUEUE_DEPTH];
    logic [IDX_W-1:0] fifo_d [QUEUE_DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [STV_W-1:0] starve_q, starve_d;
    logic [IDX_W-1:0] rr_q, rr_d;

    logic [CNT-1:0]   np_valid;
    logic             np_any;
    logic [IDX_W-1:0] rr_sel;
    logic             rr_hit;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] rr_next;
    logic [IDX_W-1:0] head_idx;
    logic             full;
    logic             empty;
    logic             issue;
    logic             pop;
    int               nxt;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign head_idx = fifo_q[head_q];

    // First valid non-privileged master at or after rr, cyclic.
    always_comb begin
        np_valid           = master_req_valid;
        np_valid[PRIO_IDX] = 1'b0;
        np_any             = |np_valid;
        rr_hit             = 1'b0;
        rr_sel             = rr_q;
        cand               = rr_q;
        for (int k = 0; k < CNT; k++) begin
            cand = IDX_W'((int'(rr_q) + k) % CNT);
            if (!rr_hit && np_valid[cand]) begin
                rr_hit = 1'b1;
                rr_sel = cand;
            end
        end
    end

    always_comb begin
        if (lock_q) begin
            sel = lock_idx_q;
        end else if ((starve_q == STV_MAX) && np_any) begin
            sel = rr_sel;
        end else if (master_req_valid[PRIO]) begin
            sel = PRIO;
        end else begin
            sel = rr_sel;
        end
    end

    // Round-robin successor of the granted master, never landing on PRIO_IDX.
    always_comb begin
        nxt = (int'(sel) + 1) % CNT;
        if (nxt == PRIO_IDX) begin
            nxt = (nxt + 1) % CNT;
        end
        rr_next = IDX_W'(nxt);
    end

    assign slave_req_valid  = master_req_valid[sel] && !full && !rst;
    assign slave_req_data   = master_req_data[sel];
    assign issue            = slave_req_valid && slave_req_ready;
    assign slave_resp_ready = master_resp_ready[head_idx] && !empty && !rst;
    assign pop              = slave_resp_valid && slave_resp_ready;

    always_comb begin
        for (int i = 0; i < CNT; i++) begin
            master_req_ready[i]  = (sel == IDX_W'(i)) && slave_req_ready && !full && !rst;
            master_resp_valid[i] = (head_idx == IDX_W'(i)) && slave_resp_valid && !empty && !rst;
            master_resp_data[i]  = slave_resp_data;
        end
    end

    always_comb begin
        fifo_d     = fifo_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        starve_d   = starve_q;
        rr_d       = rr_q;

        // Hold the selection while a presented request is stalled.
        if (issue) begin
            lock_d = 1'b0;
        end else if (slave_req_valid && !slave_req_ready) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end

        if (issue) begin
            fifo_d[tail_q] = sel;
            tail_d         = (tail_q == PTR_LAST) ? '0 : tail_q + PTR_W'(1);
            if (sel == PRIO) begin
                if (!np_any) begin
                    starve_d = '0;
                end else if (starve_q != STV_MAX) begin
                    starve_d = starve_q + STV_W'(1);
                end
            end else begin
                starve_d = '0;
                rr_d     = rr_next;
            end
        end

        if (pop) begin
            head_d = (head_q == PTR_LAST) ? '0 : head_q + PTR_W'(1);
        end

        if (issue && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !issue) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < QUEUE_DEPTH; j++) begin
                fifo_q[j] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            starve_q   <= '0;
            rr_q       <= RR_INIT;
        end else begin
            fifo_q     <= fifo_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            starve_q   <= starve_d;
            rr_q       <= rr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_scheduler.sv
`default_nettype none
// ============================================================================
// tb_mem_req_scheduler : directed self-checking bench for mem_req_scheduler
// Revision             : 1.0
// ============================================================================
module tb_mem_req_scheduler;

    logic              clk;
    logic              rst;
    logic [1:0]        master_req_valid;
    logic [1:0]        master_req_ready;
    logic [1:0][31:0]  master_req_data;
    logic [1:0]        master_resp_valid;
    logic [1:0]        master_resp_ready;
    logic [1:0][31:0]  master_resp_data;
    logic              slave_req_valid;
    logic              slave_req_ready;
    logic [31:0]       slave_req_data;
    logic              slave_resp_valid;
    logic              slave_resp_ready;
    logic [31:0]       slave_resp_data;

    int n_checks;
    int n_fail;
    int outst;
    int exp_seq [10];

    mem_req_scheduler #(
        .CNT          (2),
        .QUEUE_DEPTH  (2),
        .PRIO_IDX     (1),
        .STARVE_LIMIT (4),
        .ADDR_W       (32),
        .DATA_W       (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .master_req_valid  (master_req_valid),
        .master_req_ready  (master_req_ready),
        .master_req_data   (master_req_data),
        .master_resp_valid (master_resp_valid),
        .master_resp_ready (master_resp_ready),
        .master_resp_data  (master_resp_data),
        .slave_req_valid   (slave_req_valid),
        .slave_req_ready   (slave_req_ready),
        .slave_req_data    (slave_req_data),
        .slave_resp_valid  (slave_resp_valid),
        .slave_resp_ready  (slave_resp_ready),
        .slave_resp_data   (slave_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst               = 1'b1;
        master_req_valid  = '0;
        master_req_data   = '0;
        master_resp_ready = '0;
        slave_req_ready   = 1'b0;
        slave_resp_valid  = 1'b0;
        slave_resp_data   = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_seq  = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        // Reset state: nothing offered, spurious response held off.
        apply_reset();
        slave_resp_valid = 1'b1;
        @(negedge clk);
        check("rst_req_valid", 64'(slave_req_valid), 64'h0);
        check("rst_resp_ready", 64'(slave_resp_ready), 64'h0);
        check("rst_mresp_valid", 64'(master_resp_valid), 64'h0);
        next_cycle();

        // Single master 0 request and response.
        apply_reset();
        master_req_valid   = 2'b01;
        master_req_data[0] = 32'h8000_0000;
        slave_req_ready    = 1'b1;
        master_resp_ready  = 2'b11;
        @(negedge clk);
        check("t1_req_valid", 64'(slave_req_valid), 64'h1);
        check("t1_req_data", 64'(slave_req_data), 64'h8000_0000);
        check("t1_mreq_ready", 64'(master_req_ready), 64'h1);
        next_cycle();
        master_req_valid = 2'b00;
        next_cycle();
        next_cycle();
        slave_resp_valid = 1'b1;
        slave_resp_data  = 32'h0000_DEAD;
        @(negedge clk);
        check("t1_mresp_valid", 64'(master_resp_valid), 64'h1);
        check("t1_mresp_data", 64'(master_resp_data[0]), 64'hDEAD);
        check("t1_resp_ready", 64'(slave_resp_ready), 64'h1);
        next_cycle();
        @(negedge clk);
        check("t1_spurious_ready", 64'(slave_resp_ready), 64'h0);
        check("t1_spurious_valid", 64'(master_resp_valid), 64'h0);
        next_cycle();

        // Starvation: both masters valid every cycle.
        apply_reset();
        master_req_valid   = 2'b11;
        master_req_data[0] = 32'h0000_0A00;
        master_req_data[1] = 32'h0000_0A01;
        slave_req_ready    = 1'b1;
        master_resp_ready  = 2'b11;
        outst              = 0;
        for (int i = 0; i < 10; i++) begin
            slave_resp_valid = (outst > 0);
            slave_resp_data  = 32'(i);
            @(negedge clk);
            check($sformatf("t2_grant%0d", i), 64'(master_req_ready),
                  (exp_seq[i] == 1) ? 64'h2 : 64'h1);
            next_cycle();
            outst = outst + 1 - (slave_resp_valid ? 1 : 0);
        end

        // Lock: master 0 stalled, privileged master arrives meanwhile.
        apply_reset();
        master_req_valid   = 2'b01;
        master_req_data[0] = 32'h1000_0000;
        master_req_data[1] = 32'h2000_0000;
        master_resp_ready  = 2'b11;
        @(negedge clk);
        check("t3_valid_c1", 64'(slave_req_valid), 64'h1);
        check("t3_data_c1", 64'(slave_req_data), 64'h1000_0000);
        next_cycle();
        master_req_valid = 2'b11;
        @(negedge clk);
        check("t3_data_c2", 64'(slave_req_data), 64'h1000_0000);
        next_cycle();
        @(negedge clk);
        check("t3_data_c3", 64'(slave_req_data), 64'h1000_0000);
        next_cycle();
        slave_req_ready = 1'b1;
        @(negedge clk);
        check("t3_data_fire", 64'(slave_req_data), 64'h1000_0000);
        check("t3_ready_fire", 64'(master_req_ready), 64'h1);
        next_cycle();
        master_req_valid = 2'b10;
        @(negedge clk);
        check("t3_data_next", 64'(slave_req_data), 64'h2000_0000);
        check("t3_ready_next", 64'(master_req_ready), 64'h2);
        next_cycle();

        // Full FIFO: pop and blocked push in the same cycle.
        apply_reset();
        master_req_valid   = 2'b10;
        master_req_data[1] = 32'h0000_0C00;
        slave_req_ready    = 1'b1;
        master_resp_ready  = 2'b11;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("t4_full_ready", 64'(master_req_ready), 64'h0);
        check("t4_full_valid", 64'(slave_req_valid), 64'h0);
        next_cycle();
        slave_resp_valid = 1'b1;
        slave_resp_data  = 32'h0000_0E01;
        @(negedge clk);
        check("t4_pop_ready", 64'(slave_resp_ready), 64'h1);
        check("t4_pop_route", 64'(master_resp_valid), 64'h2);
        check("t4_push_blocked", 64'(master_req_ready), 64'h0);
        next_cycle();
        slave_resp_valid = 1'b0;
        @(negedge clk);
        check("t4_push_next", 64'(master_req_ready), 64'h2);
        check("t4_valid_next", 64'(slave_req_valid), 64'h1);
        next_cycle();
        @(negedge clk);
        check("t4_full_again", 64'(master_req_ready), 64'h0);
        next_cycle();

        // In-order routing 1,0,1 with backpressure on master 0.
        apply_reset();
        slave_req_ready    = 1'b1;
        master_resp_ready  = 2'b11;
        master_req_valid   = 2'b10;
        master_req_data[1] = 32'h0000_00A1;
        master_req_data[0] = 32'h0000_00A0;
        @(negedge clk);
        check("t5_issue1", 64'(master_req_ready), 64'h2);
        next_cycle();
        master_req_valid = 2'b01;
        @(negedge clk);
        check("t5_issue0", 64'(master_req_ready), 64'h1);
        next_cycle();
        master_req_valid = 2'b10;
        slave_resp_valid = 1'b1;
        slave_resp_data  = 32'h0000_1111;
        @(negedge clk);
        check("t5_r1_blocked", 64'(master_req_ready), 64'h0);
        check("t5_r1_route", 64'(master_resp_valid), 64'h2);
        check("t5_r1_data", 64'(master_resp_data[1]), 64'h1111);
        next_cycle();
        slave_resp_data   = 32'h0000_2222;
        master_resp_ready = 2'b10;
        @(negedge clk);
        check("t5_issue1b", 64'(master_req_ready), 64'h2);
        check("t5_r2_route", 64'(master_resp_valid), 64'h1);
        check("t5_r2_stall", 64'(slave_resp_ready), 64'h0);
        next_cycle();
        master_req_valid = 2'b00;
        @(negedge clk);
        check("t5_r2_stall2", 64'(slave_resp_ready), 64'h0);
        next_cycle();
        master_resp_ready = 2'b11;
        @(negedge clk);
        check("t5_r2_ready", 64'(slave_resp_ready), 64'h1);
        check("t5_r2_data", 64'(master_resp_data[0]), 64'h2222);
        next_cycle();
        slave_resp_data = 32'h0000_3333;
        @(negedge clk);
        check("t5_r3_route", 64'(master_resp_valid), 64'h2);
        check("t5_r3_data", 64'(master_resp_data[1]), 64'h3333);
        next_cycle();
        slave_resp_valid = 1'b0;

        // Reset mid-operation with an outstanding entry and lock held.
        apply_reset();
        slave_req_ready    = 1'b1;
        master_resp_ready  = 2'b11;
        master_req_valid   = 2'b10;
        master_req_data[1] = 32'h0000_0B01;
        next_cycle();
        master_req_valid   = 2'b01;
        master_req_data[0] = 32'h0000_0B00;
        slave_req_ready    = 1'b0;
        @(negedge clk);
        check("t6_stall_valid", 64'(slave_req_valid), 64'h1);
        next_cycle();
        rst              = 1'b1;
        master_req_valid = 2'b11;
        slave_req_ready  = 1'b1;
        slave_resp_valid = 1'b1;
        slave_resp_data  = 32'h0000_5555;
        @(negedge clk);
        check("t6_rst_req_valid", 64'(slave_req_valid), 64'h0);
        check("t6_rst_mreq_ready", 64'(master_req_ready), 64'h0);
        check("t6_rst_mresp_valid", 64'(master_resp_valid), 64'h0);
        check("t6_rst_resp_ready", 64'(slave_resp_ready), 64'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("t6_empty_ready", 64'(slave_resp_ready), 64'h0);
        check("t6_empty_route", 64'(master_resp_valid), 64'h0);
        check("t6_fresh_data", 64'(slave_req_data), 64'h0B01);
        check("t6_fresh_ready", 64'(master_req_ready), 64'h2);
        next_cycle();
        master_req_valid = 2'b00;
        @(negedge clk);
        check("t6_fresh_route", 64'(master_resp_valid), 64'h2);
        check("t6_fresh_resp_ready", 64'(slave_resp_ready), 64'h1);
        next_cycle();
        slave_resp_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
